booth_pp_accumulator: RTL and testbench



---
 rtl/booth_pkg.sv | 27 ++
 rtl/booth_digit_decode.sv | 32 +++
 rtl/booth_pp_accumulator.sv | 114 +++++++++++
 tb/tb_booth_pp_accumulator.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// ==== booth_pkg : shared Booth radix-4 digit codes, state type and legality check | rev 1.0 ====
`default_nettype none

package booth_pkg;

  localparam int DIGIT_W = 3;

  localparam logic [DIGIT_W-1:0] BOOTH_ZERO = 3'b000;
  localparam logic [DIGIT_W-1:0] BOOTH_P1   = 3'b001;
  localparam logic [DIGIT_W-1:0] BOOTH_P2   = 3'b010;
  localparam logic [DIGIT_W-1:0] BOOTH_M1   = 3'b101;
  localparam logic [DIGIT_W-1:0] BOOTH_M2   = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } booth_state_e;

  function automatic logic is_legal_digit(input logic [DIGIT_W-1:0] code);
    return (code == BOOTH_ZERO) || (code == BOOTH_P1) || (code == BOOTH_P2) ||
           (code == BOOTH_M1)   || (code == BOOTH_M2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_digit_decode.sv
// ==== booth_digit_decode : maps one Booth digit and a multiplicand to its signed multiple | rev 1.0 ====
`default_nettype none

module booth_digit_decode
  import booth_pkg::*;
#(
  parameter int W = 40
) (
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic signed [W-1:0] mcand_i,
  output logic signed [W-1:0] multiple_o,
  output logic               illegal_o
);

  // The caller supplies a multiplicand already sign-extended with headroom for the x2 case.
  always_comb begin
    multiple_o = '0;
    unique case (digit_i)
      BOOTH_ZERO: multiple_o = '0;
      BOOTH_P1:   multiple_o = mcand_i;
      BOOTH_P2:   multiple_o = mcand_i <<< 1;
      BOOTH_M1:   multiple_o = -mcand_i;
      BOOTH_M2:   multiple_o = -(mcand_i <<< 1);
      default:    multiple_o = '0;
    endcase
  end

  assign illegal_o = !is_legal_digit(digit_i);

endmodule

`default_nettype wire

// File: rtl/booth_pp_accumulator.sv
// ==== booth_pp_accumulator : MSB-first sequential accumulation of Booth radix-4 partial products | rev 1.0 ====
`default_nettype none

module booth_pp_accumulator
  import booth_pkg::*;
#(
  parameter int NUM_DIGITS = 12,
  parameter int MCAND_W    = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DIGIT_W*NUM_DIGITS-1:0]       digits,
  input  logic [MCAND_W-1:0]                  mcand,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [2*NUM_DIGITS+MCAND_W-1:0]     product,
  output logic                                illegal_digit
);

  localparam int PROD_W = 2*NUM_DIGITS + MCAND_W;
  localparam int CNT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  booth_state_e                       state_q, state_d;
  logic [DIGIT_W*NUM_DIGITS-1:0]      digits_q, digits_d;
  logic signed [PROD_W-1:0]           mcand_q, mcand_d;
  logic signed [PROD_W-1:0]           acc_q, acc_d;
  logic                               err_q, err_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               out_valid_q, out_valid_d;

  logic [DIGIT_W-1:0]                 cur_digit;
  logic signed [PROD_W-1:0]           cur_multiple;
  logic                               cur_illegal;

  assign cur_digit = digits_q[DIGIT_W*int'(cnt_q) +: DIGIT_W];

  booth_digit_decode #(.W(PROD_W)) u_decode (
    .digit_i    (cur_digit),
    .mcand_i    (mcand_q),
    .multiple_o (cur_multiple),
    .illegal_o  (cur_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      digits_q    <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          digits_d = digits;
          mcand_d  = {{(PROD_W-MCAND_W){mcand[MCAND_W-1]}}, mcand};
          acc_d    = '0;
          err_d    = 1'b0;
          cnt_d    = CNT_W'(NUM_DIGITS-1);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Horner step: shift by one radix-4 position, then add this digit's multiple.
        acc_d = (acc_q <<< 2) + cur_multiple;
        err_d = err_q | cur_illegal;
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready      = (state_q == S_IDLE) && rst_n;
  assign out_valid     = out_valid_q;
  assign product       = acc_q;
  assign illegal_digit = err_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_pp_accumulator.sv
// ==== tb_booth_pp_accumulator : randomized self-checking bench for booth_pp_accumulator | rev 1.0 ====
`default_nettype none

module tb_booth_pp_accumulator;

  localparam int NUM_DIGITS = 12;
  localparam int MCAND_W    = 16;
  localparam int PROD_W     = 2*NUM_DIGITS + MCAND_W;
  localparam int DIG_BITS   = 3*NUM_DIGITS;
  localparam int LATENCY    = NUM_DIGITS;
  localparam int WAIT_MAX   = 60;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DIG_BITS-1:0] digits = '0;
  logic [MCAND_W-1:0]  mcand = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [PROD_W-1:0]   product;
  logic                illegal_digit;

  int checks = 0;
  int errors = 0;

  booth_pp_accumulator #(.NUM_DIGITS(NUM_DIGITS), .MCAND_W(MCAND_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .digits        (digits),
    .mcand         (mcand),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .product       (product),
    .illegal_digit (illegal_digit)
  );

  always #5 clk = ~clk;

  // Reference: product = sum over digits of value(d_i) * mcand * 4^i; illegal codes add nothing.
  function automatic logic [PROD_W-1:0] ref_product(input logic [DIG_BITS-1:0] d,
                                                    input logic [MCAND_W-1:0] m,
                                                    output bit ill);
    longint sum;
    longint mv;
    int     dv;
    logic [2:0] code;
    sum = 0;
    mv  = longint'($signed(m));
    ill = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      code = d[3*i +: 3];
      case (code)
        3'b000:  dv = 0;
        3'b001:  dv = 1;
        3'b010:  dv = 2;
        3'b101:  dv = -1;
        3'b110:  dv = -2;
        default: begin dv = 0; ill = 1'b1; end
      endcase
      sum += longint'(dv) * mv * (longint'(1) <<< (2*i));
    end
    return sum[PROD_W-1:0];
  endfunction

  function automatic logic [DIG_BITS-1:0] rand_digits(input bit allow_illegal);
    logic [DIG_BITS-1:0] d;
    logic [2:0] legal [5];
    logic [2:0] bad [3];
    legal = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};
    bad   = '{3'b011, 3'b100, 3'b111};
    d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (allow_illegal && ($urandom_range(0, 15) == 0))
        d[3*i +: 3] = bad[$urandom_range(0, 2)];
      else
        d[3*i +: 3] = legal[$urandom_range(0, 4)];
    end
    return d;
  endfunction

  // Presents one operand pair; returns at the negedge after the handshake edge.
  task automatic start_op(input logic [DIG_BITS-1:0] d, input logic [MCAND_W-1:0] m);
    @(negedge clk);
    in_valid = 1'b1;
    digits   = d;
    mcand    = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    digits   = '0;
    mcand    = '0;
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || product !== '0 || illegal_digit !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b product=%h illegal=%b in_ready=%b, required 0/0/0/0",
               out_valid, product, illegal_digit, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int n;
    bit ill;
    logic [PROD_W-1:0] exp;
    out_ready = 1'b1;
    exp = ref_product(36'h00000000D, 16'd5, ill);
    start_op(36'h00000000D, 16'd5);
    wait_out_valid(n);
    checks++;
    if (n !== LATENCY) begin
      errors++;
      $display("FAIL basic_latency: out_valid after %0d cycles, required %0d", n, LATENCY);
    end
    checks++;
    if (product !== exp || product !== 40'd15 || illegal_digit !== 1'b0) begin
      errors++;
      $display("FAIL basic_product: product=%0d illegal=%b, required 15 illegal=0",
               $signed(product), illegal_digit);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== exp) begin
      errors++;
      $display("FAIL basic_return_idle: in_ready=%b out_valid=%b product=%h, required 1/0/%h",
               in_ready, out_valid, product, exp);
    end
  endtask

  task automatic test_extremes();
    int n;
    bit ill;
    logic [PROD_W-1:0] exp;
    logic [PROD_W-1:0] lit;
    exp = ref_product(36'hC00000000, 16'h7FFF, ill);
    lit = -40'sd274869518336;
    start_op(36'hC00000000, 16'h7FFF);
    wait_out_valid(n);
    checks++;
    if (!out_valid || product !== exp || product !== lit || illegal_digit !== 1'b0) begin
      errors++;
      $display("FAIL extreme_negative: valid=%b product=%h illegal=%b, required product=%h illegal=0",
               out_valid, product, illegal_digit, lit);
    end
    @(negedge clk);
    exp = ref_product(36'h400000005, 16'h8000, ill);
    lit = -40'sd274877874176;
    start_op(36'h400000005, 16'h8000);
    wait_out_valid(n);
    checks++;
    if (!out_valid || product !== exp || product !== lit || illegal_digit !== 1'b0) begin
      errors++;
      $display("FAIL extreme_mixed: valid=%b product=%h illegal=%b, required product=%h illegal=0",
               out_valid, product, illegal_digit, lit);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int n;
    start_op(36'h000000003, 16'd7);
    wait_out_valid(n);
    checks++;
    if (!out_valid || product !== '0 || illegal_digit !== 1'b1) begin
      errors++;
      $display("FAIL illegal_flag: valid=%b product=%h illegal=%b, required product=0 illegal=1",
               out_valid, product, illegal_digit);
    end
    @(negedge clk);
    start_op(36'h000000001, 16'd7);
    wait_out_valid(n);
    checks++;
    if (!out_valid || product !== 40'd7 || illegal_digit !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clears: valid=%b product=%h illegal=%b, required product=7 illegal=0",
               out_valid, product, illegal_digit);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    bit ill;
    logic [DIG_BITS-1:0] d;
    logic [MCAND_W-1:0]  m;
    logic [PROD_W-1:0]   exp;
    d = rand_digits(1'b0);
    m = MCAND_W'($urandom);
    exp = ref_product(d, m, ill);
    out_ready = 1'b0;
    start_op(d, m);
    wait_out_valid(n);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || product !== exp || in_ready !== 1'b0 || illegal_digit !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b product=%h ready=%b, required 1/%h/0",
                 i, out_valid, product, in_ready, exp);
      end
      in_valid = 1'b1;
      digits   = rand_digits(1'b0);
      mcand    = MCAND_W'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== exp) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b ready=%b product=%h, required 0/1/%h",
               out_valid, in_ready, product, exp);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_no_accept: valid=%b ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int spurious;
    bit ill;
    logic [PROD_W-1:0] exp;
    start_op(36'h0000000D5, 16'h1234);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || product !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: valid=%b product=%h ready=%b, required 0/0/0",
               out_valid, product, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run_ready: in_ready=%b, required 1", in_ready);
    end
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      errors++;
      $display("FAIL reset_mid_run_spurious: out_valid seen %0d cycles, required 0", spurious);
    end
    exp = ref_product(36'h0000000D5, 16'h1234, ill);
    start_op(36'h0000000D5, 16'h1234);
    wait_out_valid(n);
    checks++;
    if (n !== LATENCY || product !== exp || illegal_digit !== ill) begin
      errors++;
      $display("FAIL reset_mid_run_fresh: cycles=%0d product=%h illegal=%b, required %0d/%h/%b",
               n, product, illegal_digit, LATENCY, exp, ill);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int n;
    bit ill;
    logic [DIG_BITS-1:0] d;
    logic [MCAND_W-1:0]  m;
    logic [PROD_W-1:0]   exp;
    for (int t = 0; t < 40; t++) begin
      d = rand_digits(1'b1);
      m = MCAND_W'($urandom);
      exp = ref_product(d, m, ill);
      out_ready = ($urandom_range(0, 1) == 1);
      start_op(d, m);
      wait_out_valid(n);
      checks++;
      if (n !== LATENCY || product !== exp || illegal_digit !== ill) begin
        errors++;
        $display("FAIL random[%0d]: d=%h m=%h cycles=%0d product=%h illegal=%b, required %0d/%h/%b",
                 t, d, m, n, product, illegal_digit, LATENCY, exp, ill);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_illegal();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
